// File: rtl/fetch_prefetch_pkg.sv
// Shared fetch-path constants and ISA opcode encodings (IIII XXX YYY), reused by the control unit.
package fetch_prefetch_pkg;

  localparam int DEF_INSTR_W = 10;
  localparam int DEF_PC_W    = 16;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_DEPTH   = 4;
  localparam logic [DEF_PC_W-1:0] DEF_RESET_PC = '0;

  typedef enum logic [3:0] {
    OP_MV   = 4'h0,
    OP_MVI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_MVNZ = 4'h6
  } opcode_t;

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Prefetch FIFO with flush: combinational head read, wrap-bit pointers for full/empty.
// Push while full is dropped unless a pop frees the slot in the same cycle; pop while empty is ignored.
module fetch_prefetch_fifo
  import fetch_prefetch_pkg::*;
#(
  parameter int W     = DEF_INSTR_W + DEF_PC_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          head_vld,
  output logic [AW:0]   count
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         empty, full, do_push, do_pop;

  assign count    = wr_q - rd_q;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem_q[rd_q[AW-1:0]];
  assign head_vld = ~empty;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= push_dat;
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch: walks the PC through a 1-cycle ROM into a prefetch FIFO, ir_valid 2 cycles after reset/redirect.
// Issue is credit-limited (FIFO occupancy plus in-flight response); a redirect flushes, squashes and bypasses its target.
module fetch_prefetch
  import fetch_prefetch_pkg::*;
#(
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_q,
  output logic [INSTR_W-1:0] ir,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [PC_W-1:0]    fetch_pc,
  output logic [CW-1:0]      count
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [PC_W-1:0] issue_pc;
  logic [CW-1:0]   credit_used;
  logic            push, pop;

  // The in-flight response already owns a FIFO slot, so it is counted against the depth.
  assign credit_used = count + CW'(rsp_valid_q);
  assign issue_pc    = redirect ? redirect_pc : fetch_pc_q;
  assign rom_en      = resetn & (redirect | (credit_used < CW'(DEPTH)));
  assign rom_addr    = issue_pc[ADDR_W-1:0];
  assign fetch_pc    = fetch_pc_q;

  assign push = rsp_valid_q & ~redirect;
  assign pop  = ir_valid & ir_ready & ~redirect;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = rom_en;
    if (rom_en) begin
      fetch_pc_d = issue_pc + PC_W'(1);
      rsp_pc_d   = issue_pc;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q  <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
    end
  end

  fetch_prefetch_fifo #(
    .W     (INSTR_W + PC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .flush    (redirect),
    .push     (push),
    .push_dat ({rom_q, rsp_pc_q}),
    .pop      (pop),
    .head_dat ({ir, ir_pc}),
    .head_vld (ir_valid),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scoreboard bench for fetch_prefetch: expected PC streams are queued at each reset/redirect and checked on every handshake.
module tb_fetch_prefetch;
  import fetch_prefetch_pkg::*;

  localparam int IW = DEF_INSTR_W;
  localparam int PW = DEF_PC_W;
  localparam int AW = DEF_ADDR_W;
  localparam int D  = DEF_DEPTH;
  localparam int CW = $clog2(D) + 1;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          redirect = 1'b0;
  logic [PW-1:0] redirect_pc = '0;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_q = '0;
  logic [IW-1:0] ir;
  logic [PW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [PW-1:0] fetch_pc;
  logic [CW-1:0] count;

  logic [IW-1:0]    rom [16];
  logic [IW+PW-1:0] exp_q [$];
  logic [PW-1:0]    tail_pc = '0;
  int               n_checks = 0;
  int               n_fail = 0;

  fetch_prefetch dut (
    .clock       (clock),
    .resetn      (resetn),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .fetch_pc    (fetch_pc),
    .count       (count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (rom_en) rom_q <= rom[rom_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: after a reset or redirect the stage emits target, target+1, ... with PC wrapping mod 2^16.
  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back({rom[tail_pc[AW-1:0]], tail_pc});
      tail_pc = tail_pc + 16'd1;
    end
  endtask

  task automatic start_stream(input logic [PW-1:0] pc);
    exp_q.delete();
    tail_pc = pc;
    topup();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    topup();
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    logic [IW+PW-1:0] e;
    if (resetn) begin
      check("vld_vs_count", 32'(ir_valid), 32'(count != '0));
      check("count_le_depth", 32'(count <= CW'(D)), 1);
      if (ir_valid && ir_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", 32'(ir_pc), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_ir_pc", 32'(ir_pc), 32'(e[PW-1:0]));
          check("sb_ir", 32'(ir), 32'(e[IW+PW-1:PW]));
        end
      end
    end
  end

  // Reset, release with ir_ready low, and let the FIFO fill to its credit limit.
  task automatic saturate();
    resetn = 1'b0; ir_ready = 1'b0; redirect = 1'b0;
    exp_q.delete();
    mid();
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_rom_en", 32'(rom_en), 0);
    tick();
    resetn = 1'b1;
    start_stream(DEF_RESET_PC);
    for (int c = 0; c < 8; c++) begin
      mid();
      if (c < 3) check("sat_latency", 32'(ir_valid), 32'(c == 2));
      tick();
    end
    mid();
    check("sat_count", 32'(count), 4);
    check("sat_rom_en", 32'(rom_en), 0);
    check("sat_fetch_pc", 32'(fetch_pc), 4);
    tick();
  endtask

  initial begin
    int r;
    for (int i = 0; i < 16; i++) rom[i] = 10'h040 + 10'(i);

    resetn = 1'b0; ir_ready = 1'b1;
    mid();
    check("rst_ir_valid", 32'(ir_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_fetch_pc", 32'(fetch_pc), 0);
    check("rst_rom_en", 32'(rom_en), 0);
    check("rst_ir", 32'(ir), 0);
    check("rst_ir_pc", 32'(ir_pc), 0);
    tick(); tick();

    resetn = 1'b1;
    start_stream(DEF_RESET_PC);
    mid();
    check("c0_rom_en", 32'(rom_en), 1);
    check("c0_rom_addr", 32'(rom_addr), 0);
    check("c0_ir_valid", 32'(ir_valid), 0);
    tick();
    mid();
    check("c1_ir_valid", 32'(ir_valid), 0);
    tick();
    mid();
    check("c2_ir_valid", 32'(ir_valid), 1);
    check("c2_ir", 32'(ir), 32'h040);
    check("c2_ir_pc", 32'(ir_pc), 0);
    tick();
    for (int c = 0; c < 5; c++) begin
      mid();
      check("sustain_vld", 32'(ir_valid), 1);
      tick();
    end

    saturate();
    ir_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mid();
      check("drain_nogap", 32'(ir_valid), 1);
      tick();
    end

    saturate();
    ir_ready = 1'b1;
    mid(); tick();
    mid(); tick();
    ir_ready = 1'b0;
    mid(); tick();
    redirect = 1'b1; redirect_pc = 16'd9;
    start_stream(16'd9);
    mid();
    check("pre_redir_count", 32'(count), 3);
    check("pre_redir_head", 32'(ir_pc), 2);
    check("redir_rom_en", 32'(rom_en), 1);
    check("redir_rom_addr", 32'(rom_addr), 9);
    tick();
    redirect = 1'b0;
    mid();
    check("flush_count", 32'(count), 0);
    check("flush_ir_valid", 32'(ir_valid), 0);
    tick();
    ir_ready = 1'b1;
    mid();
    check("redir_head_vld", 32'(ir_valid), 1);
    check("redir_head_pc", 32'(ir_pc), 9);
    check("redir_head_ir", 32'(ir), 32'h049);
    tick();

    redirect = 1'b1; redirect_pc = 16'hFFFF;
    start_stream(16'hFFFF);
    mid();
    check("wrap_addr_f", 32'(rom_addr), 32'hF);
    tick();
    redirect = 1'b0;
    mid();
    check("wrap_addr_0", 32'(rom_addr), 0);
    check("wrap_fetch_pc", 32'(fetch_pc), 0);
    tick();
    mid();
    check("wrap_pc_ffff", 32'(ir_pc), 32'hFFFF);
    tick();
    mid();
    check("wrap_pc_0", 32'(ir_pc), 0);
    tick();

    for (int c = 0; c < 3; c++) begin mid(); tick(); end
    redirect = 1'b1; redirect_pc = 16'd3;
    start_stream(16'd3);
    mid();
    check("dbl_first_vld", 32'(ir_valid), 1);
    tick();
    redirect_pc = 16'd7;
    start_stream(16'd7);
    mid();
    check("dbl_second_addr", 32'(rom_addr), 7);
    tick();
    redirect = 1'b0;
    mid();
    check("dbl_count", 32'(count), 0);
    tick();
    mid();
    check("dbl_head_pc", 32'(ir_pc), 7);
    check("dbl_head_ir", 32'(ir), 32'h047);
    tick();

    for (int c = 0; c < 2000; c++) begin
      r = $urandom_range(0, 199);
      ir_ready = ($urandom_range(0, 9) < 7);
      redirect = 1'b0;
      if (r < 2) begin
        resetn = 1'b0;
        exp_q.delete();
      end else if (!resetn) begin
        resetn = 1'b1;
        start_stream(DEF_RESET_PC);
      end else if (r < 14) begin
        redirect = 1'b1;
        redirect_pc = 16'($urandom);
        start_stream(redirect_pc);
      end
      mid();
      tick();
    end

    resetn = 1'b1; redirect = 1'b0;
    for (int c = 0; c < 4; c++) begin mid(); tick(); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
